// File: rtl/histo_bin_sequencer.sv
// ---------------------------------------------------------------------------
// histo_bin_sequencer
//
// Sequencer for the 256-bin grey-level histogram RAM on the camera path.
//   * After reset it sweeps the RAM and writes zero to every bin.
//   * During active video, each valid pixel triggers a read-modify-write
//     increment of bin[pix_val]. Forwarding from the two most recent writes
//     lets identical pixels arrive back to back.
//   * On a rising VS edge it drains the increment pipeline. It then reads
//     out all 256 bins in order, clearing each bin in the cycle its count
//     is presented.
//
// Optional build macro:
//   HISTO_AREA_EN - builds the running-area accumulator behind hist_area.
//                   Without it, hist_area is tied to zero.
//
// Ports:
//   iClk, iRST_N        clock, asynchronous active-low reset
//   VS                  vertical sync (high in blanking), iClk domain
//   pix_valid, pix_val  pixel strobe and grey level (= bin address)
//   ram_rd_addr         RAM read address (combinational)
//   ram_rd_data         RAM read data, one cycle after the address
//   ram_wr_en/addr/data registered RAM write port
//   hist_valid/bin      dump output strobe and bin index
//   hist_count          count of hist_bin
//   hist_area           running sum of counts up to hist_bin
//   frame_done          one-cycle pulse following bin 255
//   busy                high whenever not accumulating
// ---------------------------------------------------------------------------
module histo_bin_sequencer #(
    parameter int BINS  = 256,
    parameter int CNT_W = 19
) (
    input  logic             iClk,
    input  logic             iRST_N,
    input  logic             VS,
    input  logic             pix_valid,
    input  logic [7:0]       pix_val,
    output logic [7:0]       ram_rd_addr,
    input  logic [CNT_W-1:0] ram_rd_data,
    output logic             ram_wr_en,
    output logic [7:0]       ram_wr_addr,
    output logic [CNT_W-1:0] ram_wr_data,
    output logic             hist_valid,
    output logic [7:0]       hist_bin,
    output logic [CNT_W-1:0] hist_count,
    output logic [CNT_W+7:0] hist_area,
    output logic             frame_done,
    output logic             busy
);

    localparam logic [7:0]       LAST_BIN = 8'(BINS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        INIT_CLR = 3'd0,
        ACCUM    = 3'd1,
        DRAIN    = 3'd2,
        DUMP     = 3'd3,
        WAIT_LOW = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [8:0]       cnt_q;        // sweep / drain counter; bit 8 marks the end of the dump reads
    logic             vs_d;

    // Increment pipeline. S0 is the read issue; S2 is the ram_wr_* register.
    logic             s1_vld;
    logic [7:0]       s1_addr;
    logic             s3_vld;       // shadow of the last committed write
    logic [7:0]       s3_addr;
    logic [CNT_W-1:0] s3_data;

    // Dump output stage: the bin whose read data is on ram_rd_data now.
    logic             out_vld;
    logic [7:0]       out_bin;
    logic             frame_done_q;

    logic             s0_fire;
    logic             vs_rise;
    logic [CNT_W-1:0] inc_base;
    logic [CNT_W-1:0] inc_val;
    logic             wr_en_d;
    logic [7:0]       wr_addr_d;
    logic [CNT_W-1:0] wr_data_d;

    assign vs_rise = VS && !vs_d;
    assign s0_fire = (state_q == ACCUM) && pix_valid;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge iClk or negedge iRST_N) begin
        if (!iRST_N) state_q <= INIT_CLR;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT_CLR: if (cnt_q[7:0] == LAST_BIN) state_d = ACCUM;
            ACCUM:    if (vs_rise)                 state_d = DRAIN;
            DRAIN:    if (cnt_q[0])                state_d = DUMP;
            DUMP:     if (frame_done_q)            state_d = WAIT_LOW;
            WAIT_LOW: if (!VS)                     state_d = ACCUM;
            default:                               state_d = INIT_CLR;
        endcase
    end

    // Counter restarts at zero on every state change, so each state sees 0..N.
    always_ff @(posedge iClk or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt_q <= '0;
            vs_d  <= 1'b0;
        end else begin
            vs_d <= VS;
            if (state_d != state_q)
                cnt_q <= '0;
            else if (state_q == INIT_CLR || state_q == DRAIN ||
                     (state_q == DUMP && !cnt_q[8]))
                cnt_q <= cnt_q + 9'd1;
        end
    end

    // ---------------------------------------------------------- read port
    always_comb begin
        ram_rd_addr = '0;
        case (state_q)
            ACCUM:   ram_rd_addr = pix_val;
            DUMP:    ram_rd_addr = cnt_q[7:0];
            default: ram_rd_addr = '0;
        endcase
    end

    // --------------------------------------------------------- increment
    // The newest pending write wins. The S3 shadow is also correct when it
    // is stale: it is always the latest value written to its own address.
    always_comb begin
        inc_base = ram_rd_data;
        if (ram_wr_en && ram_wr_addr == s1_addr)
            inc_base = ram_wr_data;
        else if (s3_vld && s3_addr == s1_addr)
            inc_base = s3_data;
        inc_val = (inc_base == CNT_MAX) ? inc_base : inc_base + 1'b1;
    end

    // The write port is shared by init clear, dump clear and increments.
    // These sources never overlap in time.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        if (state_q == INIT_CLR) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q[7:0];
        end else if (out_vld) begin
            wr_en_d   = 1'b1;
            wr_addr_d = out_bin;
        end else if (s1_vld) begin
            wr_en_d   = 1'b1;
            wr_addr_d = s1_addr;
            wr_data_d = inc_val;
        end
    end

    always_ff @(posedge iClk or negedge iRST_N) begin
        if (!iRST_N) begin
            s1_vld       <= 1'b0;
            s1_addr      <= '0;
            ram_wr_en    <= 1'b0;
            ram_wr_addr  <= '0;
            ram_wr_data  <= '0;
            s3_vld       <= 1'b0;
            s3_addr      <= '0;
            s3_data      <= '0;
            out_vld      <= 1'b0;
            out_bin      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            s1_vld      <= s0_fire;
            s1_addr     <= pix_val;
            ram_wr_en   <= wr_en_d;
            ram_wr_addr <= wr_addr_d;
            ram_wr_data <= wr_data_d;
            if (ram_wr_en) begin
                s3_vld  <= 1'b1;
                s3_addr <= ram_wr_addr;
                s3_data <= ram_wr_data;
            end
            out_vld      <= (state_q == DUMP) && !cnt_q[8];
            out_bin      <= cnt_q[7:0];
            frame_done_q <= out_vld && (out_bin == LAST_BIN);
        end
    end

    // ----------------------------------------------------------- outputs
    // The count comes straight from the RAM. It is gated so that every
    // output reads zero outside a dump cycle and during reset.
    assign hist_valid = out_vld;
    assign hist_bin   = out_vld ? out_bin : '0;
    assign hist_count = out_vld ? ram_rd_data : '0;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != ACCUM);

`ifdef HISTO_AREA_EN
    logic [CNT_W+7:0] area_q;
    logic [CNT_W+7:0] area_sum;

    assign area_sum = area_q + {8'd0, hist_count};

    always_ff @(posedge iClk or negedge iRST_N) begin
        if (!iRST_N)
            area_q <= '0;
        else if (state_q == DRAIN && state_d == DUMP)
            area_q <= '0;
        else if (out_vld)
            area_q <= area_sum;
    end

    assign hist_area = out_vld ? area_sum : '0;
`else
    assign hist_area = '0;
`endif

endmodule

// File: tb/tb_histo_bin_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for histo_bin_sequencer. A behavioural RAM provides one cycle of
// read latency and returns old data on read-during-write. Frames are driven
// from a vector table, followed by directed sequences for VS-edge pixels,
// saturation, full-frame area and reset during a dump.
// ---------------------------------------------------------------------------
module tb_histo_bin_sequencer;

`ifdef HISTO_AREA_EN
    localparam bit AREA_ON = 1'b1;
`else
    localparam bit AREA_ON = 1'b0;
`endif

    logic        iClk = 1'b0;
    logic        iRST_N = 1'b0;
    logic        VS = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_val = '0;
    logic [7:0]  ram_rd_addr;
    logic [18:0] ram_rd_data = '0;
    logic        ram_wr_en;
    logic [7:0]  ram_wr_addr;
    logic [18:0] ram_wr_data;
    logic        hist_valid;
    logic [7:0]  hist_bin;
    logic [18:0] hist_count;
    logic [26:0] hist_area;
    logic        frame_done;
    logic        busy;

    histo_bin_sequencer dut (
        .iClk(iClk), .iRST_N(iRST_N), .VS(VS),
        .pix_valid(pix_valid), .pix_val(pix_val),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .hist_valid(hist_valid), .hist_bin(hist_bin), .hist_count(hist_count),
        .hist_area(hist_area), .frame_done(frame_done), .busy(busy)
    );

    always #5 iClk = ~iClk;

    // RAM model, plus a back door the bench uses for preloads.
    logic [18:0] mem [256];
    logic        pre_rand = 1'b0;
    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [18:0] pre_data = '0;

    always @(posedge iClk) begin
        ram_rd_data <= mem[ram_rd_addr];
        if (pre_rand)
            for (int i = 0; i < 256; i++) mem[i] <= 19'($urandom);
        else if (pre_en)
            mem[pre_addr] <= pre_data;
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    end

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    // Captures dump output at the negedge.
    logic [18:0] got [256];
    int          nvalid, ndone, first_cyc, done_cyc, order_err, area_err;
    logic [26:0] run_sum, last_area, area127;
    logic        cap_clr = 1'b0;

    always @(negedge iClk) begin
        if (cap_clr) begin
            for (int i = 0; i < 256; i++) got[i] = 19'h55555;
            nvalid = 0; ndone = 0; first_cyc = -1; done_cyc = -1;
            order_err = 0; area_err = 0; run_sum = '0; last_area = '0; area127 = '0;
        end else begin
            if (hist_valid) begin
                if (nvalid == 0) first_cyc = cyc;
                if (hist_bin != nvalid[7:0]) order_err++;
                got[hist_bin] = hist_count;
                run_sum = run_sum + 27'(hist_count);
                if (hist_area != (AREA_ON ? run_sum : 27'd0)) area_err++;
                if (hist_bin == 8'd127) area127 = hist_area;
                if (hist_bin == 8'd255) last_area = hist_area;
                nvalid++;
            end
            if (frame_done) begin
                ndone++;
                done_cyc = cyc;
            end
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic pix(input logic [7:0] v);
        pix_valid = 1'b1;
        pix_val   = v;
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic clr_cap();
        cap_clr = 1'b1;
        tick();
        cap_clr = 1'b0;
    endtask

    // Raises VS (a pixel the caller has already set up joins this cycle).
    // Then waits, with bounds, for frame_done and the return to accumulate.
    task automatic run_dump(output int vcyc, output bit ok);
        int k;
        VS   = 1'b1;
        vcyc = cyc;
        tick();
        pix_valid = 1'b0;
        repeat (5) tick();
        VS = 1'b0;
        k = 0;
        while (ndone == 0 && k < 400) begin tick(); k++; end
        ok = (ndone != 0);
        k = 0;
        while (busy && k < 20) begin tick(); k++; end
        if (busy) ok = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int vcyc, input bit ok);
        chk({tag, "_completed"}, ok, 1);
        chk({tag, "_nvalid"}, nvalid, 256);
        chk({tag, "_ndone"}, ndone, 1);
        chk({tag, "_first_lat"}, first_cyc - vcyc, 4);
        chk({tag, "_done_lat"}, done_cyc - vcyc, 260);
        chk({tag, "_order_err"}, order_err, 0);
        chk({tag, "_area_err"}, area_err, 0);
    endtask

    function automatic int nonzero_except(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        for (int i = 0; i < 256; i++)
            if (i[7:0] != a && i[7:0] != b && got[i] != 19'd0) n++;
        return n;
    endfunction

    task automatic wait_init(output int k);
        k = 0;
        while (busy && k < 400) begin tick(); k++; end
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int          n;      // pixels, alternating a,b,a,...
        int          gap;    // idle cycles after each pixel
        logic [18:0] exp_a;
        logic [18:0] exp_b;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int  vcyc, k;
        bit  ok;

        tbl[0] = '{8'h80, 8'h80, 10, 0, 19'd10, 19'd10};  // back-to-back, same bin
        tbl[1] = '{8'd3,  8'd4,   5, 0, 19'd3,  19'd2};   // A,B,A,B,A
        tbl[2] = '{8'd0,  8'd255, 7, 1, 19'd4,  19'd3};   // edge bins, spaced by 2
        tbl[3] = '{8'd20, 8'd20,  4, 1, 19'd4,  19'd4};   // distance-2 hazard
        tbl[4] = '{8'd21, 8'd22,  5, 2, 19'd3,  19'd2};   // distance-3, no forward
        tbl[5] = '{8'd255,8'd255, 1, 0, 19'd1,  19'd1};   // single pixel, last bin

        // Reset state with the RAM filled with garbage.
        pre_rand = 1'b1;
        tick();
        pre_rand = 1'b0;
        tick();
        chk("rst_busy", busy, 1);
        chk("rst_wr_en", ram_wr_en, 0);
        chk("rst_hist_valid", hist_valid, 0);
        chk("rst_hist_count", hist_count, 0);
        chk("rst_hist_area", hist_area, 0);
        chk("rst_frame_done", frame_done, 0);

        iRST_N = 1'b1;
        wait_init(k);
        chk("init_len", k, 256);

        // Frame straight after init: every bin must read zero.
        clr_cap();
        run_dump(vcyc, ok);
        check_frame("clear", vcyc, ok);
        chk("clear_nonzero", nonzero_except(8'd0, 8'd0) + (got[0] != 0), 0);

        for (int t = 0; t < 6; t++) begin
            clr_cap();
            for (int i = 0; i < tbl[t].n; i++) begin
                pix((i % 2 == 0) ? tbl[t].a : tbl[t].b);
                repeat (tbl[t].gap) tick();
            end
            run_dump(vcyc, ok);
            check_frame($sformatf("vec%0d", t), vcyc, ok);
            chk($sformatf("vec%0d_bin_a", t), got[tbl[t].a], tbl[t].exp_a);
            chk($sformatf("vec%0d_bin_b", t), got[tbl[t].b], tbl[t].exp_b);
            chk($sformatf("vec%0d_others", t), nonzero_except(tbl[t].a, tbl[t].b), 0);
        end

        // A pixel in the VS rising-edge cycle still counts.
        clr_cap();
        pix(8'd50);
        pix_valid = 1'b1;
        pix_val   = 8'd50;
        run_dump(vcyc, ok);
        check_frame("vsedge", vcyc, ok);
        chk("vsedge_bin50", got[50], 2);

        // Saturation: preload bin 7 one short of full.
        clr_cap();
        pre_en = 1'b1; pre_addr = 8'd7; pre_data = 19'h7FFFE;
        tick();
        pre_en = 1'b0;
        tick();
        pix(8'd7); pix(8'd7); pix(8'd7);
        run_dump(vcyc, ok);
        check_frame("sat", vcyc, ok);
        chk("sat_bin7", got[7], 19'h7FFFF);

        // Larger frame: every value 8 times.
        clr_cap();
        for (int i = 0; i < 2048; i++) pix(i[7:0]);
        run_dump(vcyc, ok);
        check_frame("full", vcyc, ok);
        k = 0;
        for (int i = 0; i < 256; i++) if (got[i] != 19'd8) k++;
        chk("full_bad_bins", k, 0);
        chk("full_area127", area127, AREA_ON ? 1024 : 0);
        chk("full_area255", last_area, AREA_ON ? 2048 : 0);

        // Reset asserted while bin 100 is on the output.
        clr_cap();
        pix(8'd200); pix(8'd200); pix(8'd200);
        VS = 1'b1;
        tick();
        repeat (5) tick();
        VS = 1'b0;
        k = 0;
        while (!(hist_valid && hist_bin == 8'd100) && k < 300) begin tick(); k++; end
        chk("rstmid_reached_bin100", hist_valid && hist_bin == 8'd100, 1);
        iRST_N = 1'b0;
        #1;
        chk("rstmid_valid", hist_valid, 0);
        chk("rstmid_count", hist_count, 0);
        chk("rstmid_bin", hist_bin, 0);
        chk("rstmid_area", hist_area, 0);
        chk("rstmid_wr_en", ram_wr_en, 0);
        chk("rstmid_busy", busy, 1);
        tick();
        tick();
        iRST_N = 1'b1;
        wait_init(k);
        chk("rstmid_init_len", k, 256);

        clr_cap();
        run_dump(vcyc, ok);
        check_frame("after_rst", vcyc, ok);
        chk("after_rst_bin200", got[200], 0);
        chk("after_rst_nonzero", nonzero_except(8'd200, 8'd200), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
